// File: rtl/trace_pkg.sv
// trace_pkg: shared state encoding and entry layout for retire_trace_buffer
package trace_pkg;
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_CAPTURE = 2'd1, ST_DONE = 2'd2} state_t;
    localparam int RD_W = 5;
    function automatic int entry_w(input int xlen);
        return 2 * xlen + RD_W;
    endfunction
endpackage

// File: rtl/trace_fifo.sv
// trace_fifo: first-word-fall-through circular buffer with net occupancy count
module trace_fifo
    import trace_pkg::*;
#(
    parameter int W = 69,
    parameter int DEPTH = 16,
    parameter int CW = $clog2(DEPTH) + 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic          clear,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic do_push, do_pop;
    assign full = count == CW'(DEPTH);
    assign empty = count == '0;
    assign do_pop = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout = mem[rptr];
    always_ff @(posedge clock)
        if (do_push) mem[wptr] <= din;
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            wptr <= '0;
            rptr <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop) rptr <= rptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/retire_trace_buffer.sv
// retire_trace_buffer: captures watched register writebacks into a trace buffer; TRACE_HALT_DETECT_EN adds self-loop auto-stop
module retire_trace_buffer
    import trace_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int DEPTH = 16,
    parameter int REG_LO = 10,
    parameter int REG_HI = 15,
    parameter int HALT_CYCLES = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       i_valid,
    input  logic [XLEN-1:0]            i_pc,
    input  logic                       i_rd_we,
    input  logic [4:0]                 i_rd_addr,
    input  logic [XLEN-1:0]            i_rd_data,
    input  logic                       i_arm,
    input  logic                       i_stop,
    input  logic                       i_clear,
    output logic                       o_trace_valid,
    input  logic                       i_trace_ready,
    output logic [XLEN-1:0]            o_trace_pc,
    output logic [4:0]                 o_trace_rd,
    output logic [XLEN-1:0]            o_trace_data,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_overflow,
    output logic [1:0]                 o_state,
    output logic                       o_halted
);
    localparam int EW = entry_w(XLEN);
    localparam logic [RD_W-1:0] LO = RD_W'(REG_LO);
    localparam logic [RD_W-1:0] HI = RD_W'(REG_HI);
    state_t state, state_nx;
    logic qual, pop, halt, full, empty;
    logic [EW-1:0] head;
    assign qual = state == ST_CAPTURE && i_valid && i_rd_we && i_rd_addr != '0 && i_rd_addr >= LO && i_rd_addr <= HI;
    assign pop = o_trace_valid && i_trace_ready;
    assign o_trace_valid = !empty;
    assign {o_trace_pc, o_trace_rd, o_trace_data} = head;
    assign o_state = state;
    trace_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
        .clock(clock),
        .reset(reset),
        .push(qual),
        .pop(pop),
        .clear(i_clear),
        .din({i_pc, i_rd_addr, i_rd_data}),
        .dout(head),
        .count(o_count),
        .full(full),
        .empty(empty)
    );
    always_comb
        state_nx = i_clear ? ST_IDLE :
                   state == ST_CAPTURE ? ((i_stop || halt) ? ST_DONE : ST_CAPTURE) :
                   i_arm ? ST_CAPTURE : state;
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
            o_overflow <= 1'b0;
        end else begin
            state <= state_nx;
            o_overflow <= !i_clear && (o_overflow || (qual && full && !pop));
        end
    end
`ifdef TRACE_HALT_DETECT_EN
    localparam int HW = $clog2(HALT_CYCLES + 1);
    logic [XLEN-1:0] prev_pc;
    logic prev_ok, same;
    logic [HW-1:0] hcnt;
    assign same = i_valid && prev_ok && i_pc == prev_pc;
    assign halt = state == ST_CAPTURE && same && hcnt == HW'(HALT_CYCLES - 1);
    always_ff @(posedge clock) begin
        if (reset || state != ST_CAPTURE) begin
            prev_ok <= 1'b0;
            hcnt <= '0;
        end else if (i_valid) begin
            prev_pc <= i_pc;
            prev_ok <= 1'b1;
            hcnt <= same ? hcnt + HW'(1) : '0;
        end
    end
    always_ff @(posedge clock) begin
        if (reset || i_clear) o_halted <= 1'b0;
        else if (halt && !i_stop) o_halted <= 1'b1;
    end
`else
    assign halt = 1'b0;
    assign o_halted = 1'b0;
`endif
endmodule

// File: tb/tb_retire_trace_buffer.sv
// tb_retire_trace_buffer: vector table plus scoreboard of expected trace entries
module tb_retire_trace_buffer;
`ifdef TRACE_HALT_DETECT_EN
    localparam bit HD = 1'b1;
`else
    localparam bit HD = 1'b0;
`endif
    logic clock = 1'b0, reset = 1'b1;
    logic i_valid = 0, i_rd_we = 0, i_arm = 0, i_stop = 0, i_clear = 0, i_trace_ready = 0;
    logic [31:0] i_pc = '0, i_rd_data = '0;
    logic [4:0] i_rd_addr = '0;
    logic o_trace_valid, o_overflow, o_halted;
    logic [31:0] o_trace_pc, o_trace_data;
    logic [4:0] o_trace_rd, o_count;
    logic [1:0] o_state;
    int n_tests = 0, n_fail = 0;
    always #5 clock = ~clock;
    retire_trace_buffer dut (
        .clock(clock), .reset(reset), .i_valid(i_valid), .i_pc(i_pc), .i_rd_we(i_rd_we),
        .i_rd_addr(i_rd_addr), .i_rd_data(i_rd_data), .i_arm(i_arm), .i_stop(i_stop),
        .i_clear(i_clear), .o_trace_valid(o_trace_valid), .i_trace_ready(i_trace_ready),
        .o_trace_pc(o_trace_pc), .o_trace_rd(o_trace_rd), .o_trace_data(o_trace_data),
        .o_count(o_count), .o_overflow(o_overflow), .o_state(o_state), .o_halted(o_halted)
    );
    typedef struct {
        logic rst, valid;
        logic [31:0] pc;
        logic we;
        logic [4:0] rd;
        logic [31:0] data;
        logic arm, stop, clr, rdy, cap;
        int cnt;
        logic [1:0] st;
        logic ovf, hlt;
    } vec_t;
    typedef struct {
        logic [31:0] pc;
        logic [4:0] rd;
        logic [31:0] data;
    } ent_t;
    ent_t exp_q[$];
    vec_t t1[18];
    function automatic vec_t mk(input logic rst, valid, input logic [31:0] pc, input logic we,
                                input logic [4:0] rd, input logic [31:0] data,
                                input logic arm, stop, clr, rdy, cap, input int cnt,
                                input logic [1:0] st, input logic ovf, hlt);
        vec_t v;
        v.rst = rst; v.valid = valid; v.pc = pc; v.we = we; v.rd = rd; v.data = data;
        v.arm = arm; v.stop = stop; v.clr = clr; v.rdy = rdy; v.cap = cap;
        v.cnt = cnt; v.st = st; v.ovf = ovf; v.hlt = hlt;
        return v;
    endfunction
    function automatic vec_t wr(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] data,
                                input logic cap, input int cnt, input logic [1:0] st, input logic ovf, hlt);
        return mk(0, 1, pc, 1, rd, data, 0, 0, 0, 0, cap, cnt, st, ovf, hlt);
    endfunction
    function automatic vec_t ctl(input logic arm, stop, clr, rdy, input int cnt,
                                 input logic [1:0] st, input logic ovf, hlt);
        return mk(0, 0, 32'h0, 0, 5'd0, 32'h0, arm, stop, clr, rdy, 0, cnt, st, ovf, hlt);
    endfunction
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    task automatic apply(input vec_t v, input string nm);
        ent_t e;
        reset = v.rst; i_valid = v.valid; i_pc = v.pc; i_rd_we = v.we; i_rd_addr = v.rd;
        i_rd_data = v.data; i_arm = v.arm; i_stop = v.stop; i_clear = v.clr; i_trace_ready = v.rdy;
        #3;
        if (v.rst || v.clr) exp_q.delete();
        else if (o_trace_valid) begin
            if (exp_q.size() == 0) chk({nm, ".unexpected_head"}, 64'(o_trace_valid), 64'(0));
            else begin
                e = exp_q[0];
                chk({nm, ".head_pc"}, 64'(o_trace_pc), 64'(e.pc));
                chk({nm, ".head_rd"}, 64'(o_trace_rd), 64'(e.rd));
                chk({nm, ".head_data"}, 64'(o_trace_data), 64'(e.data));
                if (v.rdy) void'(exp_q.pop_front());
            end
        end
        if (v.cap) begin
            e.pc = v.pc; e.rd = v.rd; e.data = v.data;
            exp_q.push_back(e);
        end
        @(posedge clock);
        #1;
        chk({nm, ".count"}, 64'(o_count), 64'(v.cnt));
        chk({nm, ".valid"}, 64'(o_trace_valid), 64'(v.cnt != 0));
        chk({nm, ".state"}, 64'(o_state), 64'(v.st));
        chk({nm, ".overflow"}, 64'(o_overflow), 64'(v.ovf));
        chk({nm, ".halted"}, 64'(o_halted), 64'(v.hlt));
    endtask
    task automatic drain(input int n, input logic [1:0] st, input logic ovf, hlt, input string nm);
        for (int k = n - 1; k >= 0; k--) apply(ctl(0, 0, 0, 1, k, st, ovf, hlt), nm);
    endtask
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end
    initial begin
        t1[0]  = ctl(0, 1, 0, 0, 0, 2'd0, 0, 0);
        t1[1]  = wr(32'h100, 5'd10, 32'h1, 0, 0, 2'd0, 0, 0);
        t1[2]  = ctl(1, 0, 0, 0, 0, 2'd1, 0, 0);
        t1[3]  = wr(32'h0, 5'd10, 32'h5, 1, 1, 2'd1, 0, 0);
        t1[4]  = wr(32'h4, 5'd11, 32'h7, 1, 2, 2'd1, 0, 0);
        t1[5]  = wr(32'h8, 5'd5, 32'h9, 0, 2, 2'd1, 0, 0);
        t1[6]  = wr(32'hc, 5'd16, 32'h1, 0, 2, 2'd1, 0, 0);
        t1[7]  = mk(0, 1, 32'h10, 0, 5'd12, 32'h2, 0, 0, 0, 0, 0, 2, 2'd1, 0, 0);
        t1[8]  = mk(0, 0, 32'h14, 1, 5'd12, 32'h3, 0, 0, 0, 0, 0, 2, 2'd1, 0, 0);
        t1[9]  = wr(32'h18, 5'd15, 32'h77, 1, 3, 2'd1, 0, 0);
        t1[10] = wr(32'h1c, 5'd9, 32'h3, 0, 3, 2'd1, 0, 0);
        t1[11] = mk(0, 1, 32'h20, 1, 5'd12, 32'h99, 0, 1, 0, 0, 1, 4, 2'd2, 0, 0);
        t1[12] = wr(32'h24, 5'd13, 32'h4, 0, 4, 2'd2, 0, 0);
        t1[13] = ctl(0, 0, 0, 1, 3, 2'd2, 0, 0);
        t1[14] = ctl(0, 0, 0, 1, 2, 2'd2, 0, 0);
        t1[15] = ctl(0, 0, 0, 1, 1, 2'd2, 0, 0);
        t1[16] = ctl(0, 0, 0, 1, 0, 2'd2, 0, 0);
        t1[17] = ctl(1, 0, 0, 0, 0, 2'd1, 0, 0);
        apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0), "reset");
        apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0), "reset");
        for (int i = 0; i < 18; i++) apply(t1[i], $sformatf("basic[%0d]", i));
        apply(ctl(0, 0, 1, 0, 0, 2'd0, 0, 0), "fill_clear");
        apply(ctl(1, 0, 0, 0, 0, 2'd1, 0, 0), "fill_arm");
        for (int i = 0; i < 17; i++)
            apply(wr(32'h200 + 32'(4 * i), 5'(10 + i % 6), 32'(100 + i), i < 16,
                     (i < 16) ? i + 1 : 16, 2'd1, i == 16, 0), $sformatf("fill[%0d]", i));
        apply(mk(0, 1, 32'h400, 1, 5'd13, 32'habc, 0, 0, 0, 1, 1, 16, 2'd1, 1, 0), "full_pushpop");
        drain(16, 2'd1, 1, 0, "full_drain");
        apply(ctl(0, 0, 1, 0, 0, 2'd0, 0, 0), "halt_clear");
        apply(ctl(1, 0, 0, 0, 0, 2'd1, 0, 0), "halt_arm");
        apply(mk(0, 1, 32'h1c, 0, 5'd10, 32'h0, 0, 0, 0, 0, 0, 0, 2'd1, 0, 0), "halt_pre");
        for (int i = 0; i < 5; i++)
            apply(wr(32'h20, 5'd10, 32'(80 + i), 1, i + 1, (HD && i == 4) ? 2'd2 : 2'd1, 0, HD && i == 4),
                  $sformatf("halt[%0d]", i));
        apply(wr(32'h20, 5'd11, 32'h55, !HD, HD ? 5 : 6, HD ? 2'd2 : 2'd1, 0, HD), "halt_after");
        drain(HD ? 5 : 6, HD ? 2'd2 : 2'd1, 0, HD, "halt_drain");
        apply(ctl(1, 0, 0, 0, 0, 2'd1, 0, HD), "clr_arm");
        for (int i = 0; i < 3; i++)
            apply(wr(32'h300 + 32'(4 * i), 5'(12 + i), 32'(200 + i), 1, i + 1, 2'd1, 0, HD),
                  $sformatf("clr_wr[%0d]", i));
        apply(ctl(0, 0, 1, 1, 0, 2'd0, 0, 0), "clr_mid");
        apply(ctl(0, 0, 0, 0, 0, 2'd0, 0, 0), "clr_idle");
        apply(ctl(1, 0, 0, 0, 0, 2'd1, 0, 0), "rst_arm");
        for (int i = 0; i < 2; i++)
            apply(wr(32'h500 + 32'(4 * i), 5'd14, 32'(300 + i), 1, i + 1, 2'd1, 0, 0),
                  $sformatf("rst_wr[%0d]", i));
        apply(mk(1, 1, 32'h508, 1, 5'd14, 32'h1, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0), "rst_mid");
        apply(ctl(0, 0, 0, 1, 0, 2'd0, 0, 0), "rst_after");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
